pipe_hazard_ctrl: RTL

Pipeline controller that sequences the IF/ID and ID/MEX pipeline registers. It detects load-use hazards, control redirects (taken branch, jump) and program completion from the MEX stage. From these it drives PC-write, IF/ID write/flush, ID/MEX flush and next-PC select. It also runs a start/halt state machine and a saturating bubble counter for performance checks.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if : ID/MEX hazard inputs and pipeline control outputs
// Revision 1.0
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic       start;
  logic [2:0] ID_read_addr1;
  logic [2:0] ID_read_addr2;
  logic       ID_uses_reg2;
  logic [2:0] MEX_write_addr;
  logic       MEX_reg_write;
  logic       MEX_mem_read;
  logic       MEX_branch_ctrl;
  logic       MEX_branch_taken;
  logic       MEX_jmp_ctrl;
  logic       MEX_done_ctrl;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_mex_flush;
  logic       running;
  logic       done;
  logic [7:0] bubble_count;

  modport master (
    output start, ID_read_addr1, ID_read_addr2, ID_uses_reg2, MEX_write_addr,
           MEX_reg_write, MEX_mem_read, MEX_branch_ctrl, MEX_branch_taken,
           MEX_jmp_ctrl, MEX_done_ctrl,
    input  pc_write, pc_sel, if_id_write, if_id_flush, id_mex_flush,
           running, done, bubble_count
  );

  modport slave (
    input  start, ID_read_addr1, ID_read_addr2, ID_uses_reg2, MEX_write_addr,
           MEX_reg_write, MEX_mem_read, MEX_branch_ctrl, MEX_branch_taken,
           MEX_jmp_ctrl, MEX_done_ctrl,
    output pc_write, pc_sel, if_id_write, if_id_flush, id_mex_flush,
           running, done, bubble_count
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : IF/ID and ID/MEX sequencing with load-use/redirect hazards
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int BRANCH_BUBBLES    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Reload values are only consumed when the matching parameter allows it.
  localparam logic [3:0] C_STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 2);
  localparam logic [3:0] C_FLUSH_RELOAD = 4'(BRANCH_BUBBLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] bubble_q, bubble_d;

  logic       pc_write;
  logic [1:0] pc_sel;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_mex_flush;
  logic       running;
  logic       redirect;
  logic       load_use;

  assign running  = (state_q == S_RUN) || (state_q == S_STALL) || (state_q == S_FLUSH);
  assign redirect = bus.MEX_jmp_ctrl || (bus.MEX_branch_ctrl && bus.MEX_branch_taken);
  assign load_use = bus.MEX_mem_read && bus.MEX_reg_write &&
                    ((bus.MEX_write_addr == bus.ID_read_addr1) ||
                     (bus.ID_uses_reg2 && (bus.MEX_write_addr == bus.ID_read_addr2)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bubble_d     = bubble_q;
    pc_write     = 1'b0;
    pc_sel       = 2'b00;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_mex_flush = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if_id_flush  = 1'b1;
        id_mex_flush = 1'b1;
        if (bus.start) begin
          state_d  = S_RUN;
          bubble_d = 8'd0;
        end
      end
      S_RUN: begin
        if (bus.MEX_done_ctrl) begin
          if_id_flush  = 1'b1;
          id_mex_flush = 1'b1;
          state_d      = S_HALT;
        end else if (redirect) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_mex_flush = 1'b1;
          pc_sel       = bus.MEX_jmp_ctrl ? 2'b10 : 2'b01;
          if (BRANCH_BUBBLES > 0) begin
            state_d = S_FLUSH;
            cnt_d   = C_FLUSH_RELOAD;
          end
        end else if (load_use) begin
          id_mex_flush = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = S_STALL;
            cnt_d   = C_STALL_RELOAD;
          end
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      S_STALL: begin
        id_mex_flush = 1'b1;
        if (cnt_q == 4'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_FLUSH: begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_mex_flush = 1'b1;
        if (cnt_q == 4'd0) state_d = S_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (running && id_mex_flush && (bubble_q != 8'hFF))
      bubble_d = bubble_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      bubble_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.pc_sel       = pc_sel;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_mex_flush = id_mex_flush;
  assign bus.running      = running;
  assign bus.done         = (state_q == S_HALT);
  assign bus.bubble_count = bubble_q;

endmodule
`default_nettype wire
